// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

    localparam int unsigned NUM_ROWS       = 4;
    localparam int unsigned NUM_COLS       = 4;
    localparam int unsigned KEY_CODE_WIDTH = 4;
    localparam int unsigned IDX_WIDTH      = 2;
    localparam int unsigned CNT_WIDTH      = 4;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_e;

    // Index of the lowest-numbered active-low column.
    function automatic logic [IDX_WIDTH-1:0] lowest_low_col(input logic [NUM_COLS-1:0] col_bits);
        logic [IDX_WIDTH-1:0] idx;
        logic                 found;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_COLS; i++) begin
            if (!found && !col_bits[i]) begin
                idx   = IDX_WIDTH'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Free-running scan divider: one-cycle tick each time the counter wraps to zero.
module keypad_tick_gen #(
    parameter int unsigned SCAN_DIV_WIDTH = 16
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    logic [SCAN_DIV_WIDTH-1:0] div_q, div_d;
    logic                      tick_q, tick_d;

    always_comb begin
        div_d  = div_q + SCAN_DIV_WIDTH'(1);
        tick_d = (div_q == '1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 row-scanned keypad with debounce and a single-entry key event register.
// Auto-repeat of held keys is enabled by defining KEYPAD_SCANNER_AUTOREPEAT_EN.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV_WIDTH = 16,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned REPEAT_SCANS   = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_COLS-1:0]       cols,
    output logic [NUM_ROWS-1:0]       rows,
    output logic [KEY_CODE_WIDTH-1:0] key_code,
    output logic                      key_valid,
    input  logic                      key_ready,
    output logic                      key_held,
    output logic                      overrun
);

    localparam logic [CNT_WIDTH-1:0] DEB_MAX = CNT_WIDTH'(DEBOUNCE_SCANS);

    state_e                      state_q, state_d;
    logic [IDX_WIDTH-1:0]        row_idx_q, row_idx_d;
    logic [IDX_WIDTH-1:0]        col_idx_q, col_idx_d;
    logic [CNT_WIDTH-1:0]        count_q, count_d;
    logic [NUM_ROWS-1:0]         rows_q, rows_d;
    logic [KEY_CODE_WIDTH-1:0]   key_code_q, key_code_d;
    logic                        key_valid_q, key_valid_d;
    logic                        key_held_q, key_held_d;
    logic                        overrun_q, overrun_d;
    logic [NUM_COLS-1:0]         meta_q, sync_q;
    logic                        tick;
    logic                        col_low;
    logic                        press_ev;
    logic                        repeat_ev;
    logic                        handshake;
    logic [CNT_WIDTH-1:0]        count_inc;

    keypad_tick_gen #(
        .SCAN_DIV_WIDTH(SCAN_DIV_WIDTH)
    ) u_tick_gen (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    // Two-flop synchronizer; idle (all high) out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= cols;
            sync_q <= meta_q;
        end
    end

    assign col_low   = ~sync_q[col_idx_q];
    assign count_inc = count_q + CNT_WIDTH'(1);
    assign handshake = key_valid_q & key_ready;

`ifdef KEYPAD_SCANNER_AUTOREPEAT_EN
    localparam int unsigned        REP_WIDTH = $clog2(REPEAT_SCANS + 1);
    localparam logic [REP_WIDTH-1:0] REP_MAX = REP_WIDTH'(REPEAT_SCANS);

    logic [REP_WIDTH-1:0] rep_q, rep_d;

    // Ticks spent continuously in PRESSED; cleared whenever the FSM is elsewhere.
    always_comb begin
        rep_d     = rep_q;
        repeat_ev = 1'b0;
        if (state_q != PRESSED) begin
            rep_d = '0;
        end else if (tick && col_low) begin
            if (rep_q + REP_WIDTH'(1) == REP_MAX) begin
                repeat_ev = 1'b1;
                rep_d     = '0;
            end else begin
                rep_d = rep_q + REP_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rep_q <= '0;
        end else begin
            rep_q <= rep_d;
        end
    end
`else
    logic [31:0] unused_repeat_scans;

    assign unused_repeat_scans = 32'(REPEAT_SCANS);
    assign repeat_ev           = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        row_idx_d   = row_idx_q;
        col_idx_d   = col_idx_q;
        count_d     = count_q;
        rows_d      = rows_q;
        key_held_d  = key_held_q;
        key_code_d  = key_code_q;
        key_valid_d = key_valid_q;
        overrun_d   = overrun_q;
        press_ev    = 1'b0;

        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (sync_q != '1) begin
                        col_idx_d = lowest_low_col(sync_q);
                        count_d   = CNT_WIDTH'(1);
                        if (DEB_MAX == CNT_WIDTH'(1)) begin
                            state_d    = PRESSED;
                            key_held_d = 1'b1;
                            press_ev   = 1'b1;
                            count_d    = '0;
                        end else begin
                            state_d = DEBOUNCE;
                        end
                    end else begin
                        row_idx_d = row_idx_q + IDX_WIDTH'(1);
                        rows_d    = ~(NUM_ROWS'(1) << row_idx_d);
                    end
                end
                DEBOUNCE: begin
                    if (col_low) begin
                        count_d = count_inc;
                        if (count_inc == DEB_MAX) begin
                            state_d    = PRESSED;
                            key_held_d = 1'b1;
                            press_ev   = 1'b1;
                            count_d    = '0;
                        end
                    end else begin
                        state_d = SCAN;
                        count_d = '0;
                    end
                end
                PRESSED: begin
                    if (!col_low) begin
                        if (DEB_MAX == CNT_WIDTH'(1)) begin
                            state_d    = SCAN;
                            key_held_d = 1'b0;
                            count_d    = '0;
                        end else begin
                            state_d = RELEASE;
                            count_d = CNT_WIDTH'(1);
                        end
                    end
                end
                RELEASE: begin
                    if (!col_low) begin
                        count_d = count_inc;
                        if (count_inc == DEB_MAX) begin
                            state_d    = SCAN;
                            key_held_d = 1'b0;
                            count_d    = '0;
                        end
                    end else begin
                        state_d = PRESSED;
                        count_d = '0;
                    end
                end
                default: begin
                    state_d = SCAN;
                end
            endcase
        end

        // A new event wins over a same-cycle handshake; otherwise a pending event blocks it.
        if (press_ev || repeat_ev) begin
            if (!key_valid_q || handshake) begin
                key_code_d  = {row_idx_q, col_idx_d};
                key_valid_d = 1'b1;
                overrun_d   = 1'b0;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (handshake) begin
            key_valid_d = 1'b0;
            overrun_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= SCAN;
            row_idx_q   <= '0;
            col_idx_q   <= '0;
            count_q     <= '0;
            rows_q      <= ~NUM_ROWS'(1);
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_idx_q   <= row_idx_d;
            col_idx_q   <= col_idx_d;
            count_q     <= count_d;
            rows_q      <= rows_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rows      = rows_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: directed vector table, reset/repeat sequences,
// and randomized key activity against a tick-level behavioural model.
module tb_keypad_scanner;

`ifdef KEYPAD_SCANNER_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif
    localparam int DS = 3;
    localparam int RS = 4;

    logic        clk;
    logic        reset;
    logic [3:0]  cols;
    logic [3:0]  rows;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ready;
    logic        key_held;
    logic        overrun;
    logic [15:0] keys;

    int errors = 0;
    int checks = 0;

    keypad_scanner #(
        .SCAN_DIV_WIDTH(2),
        .DEBOUNCE_SCANS(DS),
        .REPEAT_SCANS  (RS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cols     (cols),
        .rows     (rows),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_ready(key_ready),
        .key_held (key_held),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical keypad: a pressed key pulls its column low while its row is driven low.
    always_comb begin
        cols = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (!rows[r]) begin
                for (int c = 0; c < 4; c++) begin
                    if (keys[r*4+c]) cols[c] = 1'b0;
                end
            end
        end
    end

    // Behavioural model, advanced once per scan tick.
    int         m_row, m_col, m_run, m_rep;
    bit         m_held, m_valid, m_ovr;
    logic [3:0] m_code;

    task automatic model_reset();
        m_row = 0; m_col = 0; m_run = 0; m_rep = 0;
        m_held = 1'b0; m_valid = 1'b0; m_ovr = 1'b0; m_code = 4'h0;
    endtask

    task automatic model_event(input bit ev, input bit hs);
        if (ev) begin
            if (m_valid && !hs) m_ovr = 1'b1;
            else begin
                m_code  = 4'(m_row * 4 + m_col);
                m_valid = 1'b1;
                m_ovr   = 1'b0;
            end
        end else if (hs) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
    endtask

    task automatic model_tick(input logic [15:0] k, input bit ru);
        bit hit;
        bit ev;
        int low;
        ev  = 1'b0;
        hit = k[m_row*4+m_col];
        if (!m_held) begin
            if (m_run == 0) begin
                low = -1;
                for (int c = 3; c >= 0; c--) if (k[m_row*4+c]) low = c;
                if (low < 0) m_row = (m_row + 1) % 4;
                else begin
                    m_col = low;
                    m_run = 1;
                end
            end else if (hit) m_run++;
            else m_run = 0;
            if (m_run == DS) begin
                m_held = 1'b1; m_run = 0; m_rep = 0; ev = 1'b1;
            end
        end else if (hit) begin
            if (m_run > 0) begin
                m_run = 0; m_rep = 0;
            end else begin
                m_rep++;
                if (AR && m_rep == RS) begin
                    ev = 1'b1; m_rep = 0;
                end
            end
        end else begin
            m_run++;
            if (m_run == DS) begin
                m_held = 1'b0; m_run = 0;
            end
        end
        model_event(ev, ru && m_valid);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        logic [3:0] er;
        er = 4'b1111;
        er[m_row] = 1'b0;
        chk({tag, ".rows"},      32'(rows),      32'(er));
        chk({tag, ".key_valid"}, 32'(key_valid), 32'(m_valid));
        chk({tag, ".key_code"},  32'(key_code),  32'(m_code));
        chk({tag, ".key_held"},  32'(key_held),  32'(m_held));
        chk({tag, ".overrun"},   32'(overrun),   32'(m_ovr));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".rows"},      32'(rows),      32'(4'b1110));
        chk({tag, ".key_valid"}, 32'(key_valid), 32'd0);
        chk({tag, ".key_code"},  32'(key_code),  32'd0);
        chk({tag, ".key_held"},  32'(key_held),  32'd0);
        chk({tag, ".overrun"},   32'(overrun),   32'd0);
    endtask

    // Leaves time just after the first post-reset edge, which is aligned with FSM updates.
    task automatic do_reset();
        key_ready = 1'b0;
        @(negedge clk) reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    // One scan interval: optional handshake on the first edge, optional ready on the tick edge.
    task automatic step(input logic [15:0] k, input bit ru, input bit rm);
        keys      = k;
        key_ready = rm;
        @(posedge clk);
        #1;
        key_ready = 1'b0;
        if (rm && m_valid) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
        check_model("mid");
        @(posedge clk);
        @(posedge clk);
        #1;
        key_ready = ru;
        @(posedge clk);
        #1;
        key_ready = 1'b0;
        model_tick(k, ru);
        check_model("tick");
    endtask

    typedef struct {
        logic [15:0] keys;
        bit          ru;
        bit          rm;
        logic [3:0]  rows;
        bit          valid;
        logic [3:0]  code;
        bit          held;
        bit          ovr;
    } vec_t;

    vec_t tbl[38];

    initial begin
        logic [15:0] rk;
        int          hold;
        int          nev;
        int          sel;

        tbl = '{
            '{16'h0000, 1'b0, 1'b0, 4'b1101, 1'b0, 4'h0, 1'b0, 1'b0},
            '{16'h0000, 1'b0, 1'b0, 4'b1011, 1'b0, 4'h0, 1'b0, 1'b0},
            '{16'h0000, 1'b0, 1'b0, 4'b0111, 1'b0, 4'h0, 1'b0, 1'b0},
            '{16'h0000, 1'b0, 1'b0, 4'b1110, 1'b0, 4'h0, 1'b0, 1'b0},
            '{16'h0040, 1'b0, 1'b0, 4'b1101, 1'b0, 4'h0, 1'b0, 1'b0},
            '{16'h0040, 1'b0, 1'b0, 4'b1101, 1'b0, 4'h0, 1'b0, 1'b0},
            '{16'h0040, 1'b0, 1'b0, 4'b1101, 1'b0, 4'h0, 1'b0, 1'b0},
            '{16'h0040, 1'b0, 1'b0, 4'b1101, 1'b1, 4'h6, 1'b1, 1'b0},
            '{16'h0000, 1'b0, 1'b0, 4'b1101, 1'b1, 4'h6, 1'b1, 1'b0},
            '{16'h0000, 1'b0, 1'b0, 4'b1101, 1'b1, 4'h6, 1'b1, 1'b0},
            '{16'h0000, 1'b0, 1'b0, 4'b1101, 1'b1, 4'h6, 1'b0, 1'b0},
            '{16'h0000, 1'b0, 1'b0, 4'b1011, 1'b1, 4'h6, 1'b0, 1'b0},
            '{16'h0100, 1'b0, 1'b0, 4'b1011, 1'b1, 4'h6, 1'b0, 1'b0},
            '{16'h0100, 1'b0, 1'b0, 4'b1011, 1'b1, 4'h6, 1'b0, 1'b0},
            '{16'h0000, 1'b0, 1'b0, 4'b1011, 1'b1, 4'h6, 1'b0, 1'b0},
            '{16'h0000, 1'b0, 1'b0, 4'b0111, 1'b1, 4'h6, 1'b0, 1'b0},
            '{16'h8000, 1'b0, 1'b0, 4'b0111, 1'b1, 4'h6, 1'b0, 1'b0},
            '{16'h8000, 1'b0, 1'b0, 4'b0111, 1'b1, 4'h6, 1'b0, 1'b0},
            '{16'h8000, 1'b0, 1'b0, 4'b0111, 1'b1, 4'h6, 1'b1, 1'b1},
            '{16'h8000, 1'b0, 1'b1, 4'b0111, 1'b0, 4'h6, 1'b1, 1'b0},
            '{16'h0000, 1'b0, 1'b0, 4'b0111, 1'b0, 4'h6, 1'b1, 1'b0},
            '{16'h0000, 1'b0, 1'b0, 4'b0111, 1'b0, 4'h6, 1'b1, 1'b0},
            '{16'h0000, 1'b0, 1'b0, 4'b0111, 1'b0, 4'h6, 1'b0, 1'b0},
            '{16'h0000, 1'b0, 1'b0, 4'b1110, 1'b0, 4'h6, 1'b0, 1'b0},
            '{16'h000A, 1'b0, 1'b0, 4'b1110, 1'b0, 4'h6, 1'b0, 1'b0},
            '{16'h000A, 1'b0, 1'b0, 4'b1110, 1'b0, 4'h6, 1'b0, 1'b0},
            '{16'h000A, 1'b0, 1'b0, 4'b1110, 1'b1, 4'h1, 1'b1, 1'b0},
            '{16'h0000, 1'b0, 1'b0, 4'b1110, 1'b1, 4'h1, 1'b1, 1'b0},
            '{16'h0000, 1'b0, 1'b0, 4'b1110, 1'b1, 4'h1, 1'b1, 1'b0},
            '{16'h0000, 1'b0, 1'b0, 4'b1110, 1'b1, 4'h1, 1'b0, 1'b0},
            '{16'h0000, 1'b0, 1'b0, 4'b1101, 1'b1, 4'h1, 1'b0, 1'b0},
            '{16'h0020, 1'b0, 1'b0, 4'b1101, 1'b1, 4'h1, 1'b0, 1'b0},
            '{16'h0020, 1'b0, 1'b0, 4'b1101, 1'b1, 4'h1, 1'b0, 1'b0},
            '{16'h0020, 1'b1, 1'b0, 4'b1101, 1'b1, 4'h5, 1'b1, 1'b0},
            '{16'h0020, 1'b0, 1'b1, 4'b1101, 1'b0, 4'h5, 1'b1, 1'b0},
            '{16'h0000, 1'b0, 1'b0, 4'b1101, 1'b0, 4'h5, 1'b1, 1'b0},
            '{16'h0000, 1'b0, 1'b0, 4'b1101, 1'b0, 4'h5, 1'b1, 1'b0},
            '{16'h0000, 1'b0, 1'b0, 4'b1101, 1'b0, 4'h5, 1'b0, 1'b0}
        };

        reset     = 1'b1;
        key_ready = 1'b0;
        keys      = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");

        // Directed vectors: idle scan, press/release, bounce, overrun, lowest column, coincidence.
        do_reset();
        for (int i = 0; i < 38; i++) begin
            step(tbl[i].keys, tbl[i].ru, tbl[i].rm);
            chk($sformatf("vec%0d.rows", i),      32'(rows),      32'(tbl[i].rows));
            chk($sformatf("vec%0d.key_valid", i), 32'(key_valid), 32'(tbl[i].valid));
            chk($sformatf("vec%0d.key_code", i),  32'(key_code),  32'(tbl[i].code));
            chk($sformatf("vec%0d.key_held", i),  32'(key_held),  32'(tbl[i].held));
            chk($sformatf("vec%0d.overrun", i),   32'(overrun),   32'(tbl[i].ovr));
        end

        // Reset while PRESSED, then the held key must be debounced anew.
        repeat (6) step(16'h0004, 1'b0, 1'b0);
        chk("pre_reset.key_held", 32'(key_held), 32'd1);
        chk("pre_reset.key_code", 32'(key_code), 32'd2);
        #2 reset = 1'b1;
        #1;
        check_reset_values("async_reset");
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        step(16'h0004, 1'b0, 1'b0);
        step(16'h0004, 1'b0, 1'b0);
        chk("rearm.no_early_event", 32'(key_valid), 32'd0);
        step(16'h0004, 1'b0, 1'b0);
        chk("rearm.event", 32'(key_valid), 32'd1);
        chk("rearm.code", 32'(key_code), 32'd2);
        repeat (4) step(16'h0004, 1'b0, 1'b0);
        chk("rearm.overrun", 32'(overrun), 32'(AR));

        // Long hold with the consumer always ready: count delivered events.
        do_reset();
        keys      = 16'h0004;
        key_ready = 1'b1;
        nev       = 0;
        for (int i = 0; i < 66; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (key_valid) begin
                nev++;
                chk("hold.code", 32'(key_code), 32'd2);
            end
        end
        key_ready = 1'b0;
        chk("hold.events", 32'(nev), AR ? 32'd4 : 32'd1);

        // Randomized key activity and handshakes against the model.
        keys = 16'h0000;
        do_reset();
        hold = 0;
        rk   = 16'h0000;
        for (int i = 0; i < 400; i++) begin
            if (hold == 0) begin
                hold = int'($urandom_range(10, 1));
                sel  = int'($urandom_range(9, 0));
                if (sel < 4) rk = 16'h0000;
                else if (sel < 9) rk = 16'(1) << $urandom_range(15, 0);
                else rk = (16'(1) << $urandom_range(15, 0)) | (16'(1) << $urandom_range(15, 0));
            end
            hold--;
            step(rk, ($urandom_range(4, 0) == 0), ($urandom_range(3, 0) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
